byte_cmd_initiator: RTL and testbench
=====================================

BYTE_CMD_INITIATOR -- requirements
Module: byte_cmd_initiator

Interface
REQ-001 SHALL have parameter IDLE_TIMEOUT, default 4, meaning the number of HOLD cycles (1..255) before cs is released.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port req_valid, input, 1 bit: request present.
REQ-005 SHALL have port req_ready, output, 1 bit: request accepted on a cycle where req_valid & req_ready.
REQ-006 SHALL have port req_op, input, 3 bits: 0 READ, 1 WRITE, 2 ENABLE, 3 STREAM, 4 DISABLE, 5-7 illegal.
REQ-007 SHALL have port req_addr, input, 8 bits: register address (READ and WRITE only).
REQ-008 SHALL have port req_data, input, 8 bits: write data (WRITE) or stream byte (STREAM).
REQ-009 SHALL have port cs, output, 1 bit: active-low session select to the responder.
REQ-010 SHALL have port mosi, output, 8 bits: byte to the responder, one byte per clock.
REQ-011 SHALL have port miso, input, 8 bits: responder read data.
REQ-012 SHALL have port rsp_valid, output, 1 bit: one-cycle read-data strobe.
REQ-013 SHALL have port rsp_data, output, 8 bits: captured read data.
REQ-014 SHALL have port err, output, 1 bit: one-cycle strobe for an illegal op.

Function
REQ-015 SHALL drive cs, mosi, rsp_valid, rsp_data and err from registers, with no combinational path from inputs.
REQ-016 SHALL implement the states OFF (cs=1, mosi=0x00), CMD, ADDR, DATA and HOLD (cs=0, mosi=0x00).
REQ-017 SHALL map ops to command bytes as READ=0x03, WRITE=0x02, ENABLE=0x81, STREAM=0x82, DISABLE=0x83.
REQ-018 SHALL emit these byte sequences on consecutive cycles: READ = cmd, addr, 0x00; WRITE = cmd, addr, data; ENABLE = cmd; STREAM = cmd, data; DISABLE = cmd.
REQ-019 SHALL assert req_ready in OFF, in HOLD, and in the final byte cycle of a transaction; it SHALL be 0 otherwise.
REQ-020 SHALL, on acceptance at edge k, present the command byte on mosi and cs=0 from edge k through edge k+1, with no setup cycle, including when starting from OFF.
REQ-021 SHALL, on acceptance during a final byte cycle, issue the next command byte immediately with no gap and keep cs low.
REQ-022 SHALL latch req_addr and req_data at acceptance; later changes to these inputs SHALL not alter the transaction.
REQ-023 SHALL enter HOLD after the final byte when no request is accepted, with the idle counter cleared.
REQ-024 SHALL, in HOLD, increment the idle counter each cycle and go to OFF (cs=1) on the edge where the counter reaches IDLE_TIMEOUT.
REQ-025 SHALL let an acceptance in HOLD take priority over the timeout on the same edge.
REQ-026 SHALL, for READ, sample miso on the edge that ends the 0x00 dummy-byte cycle, load rsp_data with it, and hold rsp_valid=1 for the following cycle only.
REQ-027 SHALL hold rsp_data until the next READ capture.
REQ-028 SHALL accept an illegal op (5-7) normally, pulse err for the next cycle, emit no byte, and leave the state, cs and the idle counter unchanged.
REQ-029 SHALL allow req_valid=0 in a final byte cycle, which SHALL lead to HOLD without error.

Reset
REQ-030 SHALL, while rst_n=0, immediately force state=OFF, cs=1, mosi=0x00, rsp_valid=0, rsp_data=0x00, err=0 and idle counter=0, regardless of the clock.
REQ-031 SHALL, on reset assertion mid-transaction, abandon that transaction with no resume and no rsp_valid.
REQ-032 SHALL drive req_ready=1 on the first cycle after reset release.

Verification
REQ-033 SHALL cover: from OFF, WRITE addr 0x00 data 0x03 -> cs falls with mosi=0x02, then 0x00, then 0x03 on three consecutive cycles.
REQ-034 SHALL cover: WRITE 0x08/0x61 then STREAM 0x62 with req_valid held -> mosi 02,08,61,82,62 with no gap and cs low throughout.
REQ-035 SHALL cover: READ addr 0x10 with miso=0xA5 during the dummy cycle -> exactly one rsp_valid pulse with rsp_data=0xA5, one cycle after the dummy byte.
REQ-036 SHALL cover: ENABLE then idle with IDLE_TIMEOUT=4 -> mosi=0x81, then 4 cycles of 0x00 with cs=0, then cs=1; also a request in the 4th HOLD cycle -> cs stays low.
REQ-037 SHALL cover: op=6 while in HOLD -> err pulses for 1 cycle, mosi stays 0x00, cs stays 0, and the timeout count continues.
REQ-038 SHALL cover: rst_n dropped during the ADDR cycle of a WRITE -> cs=1 and mosi=0x00 asynchronously, no data byte after release, and req_ready=1.

Source files
------------

// File: rtl/byte_cmd_initiator.sv
// byte_cmd_initiator: issues command/address/data byte sequences to a responder with session hold and idle release.
module byte_cmd_initiator #(
    parameter int IDLE_TIMEOUT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [2:0] req_op,
    input  logic [7:0] req_addr,
    input  logic [7:0] req_data,
    output logic       cs,
    output logic [7:0] mosi,
    input  logic [7:0] miso,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       err
);
    localparam logic [2:0] S_OFF  = 3'd0;
    localparam logic [2:0] S_CMD  = 3'd1;
    localparam logic [2:0] S_ADDR = 3'd2;
    localparam logic [2:0] S_DATA = 3'd3;
    localparam logic [2:0] S_HOLD = 3'd4;
    localparam logic [2:0] OP_READ    = 3'd0;
    localparam logic [2:0] OP_ENABLE  = 3'd2;
    localparam logic [2:0] OP_STREAM  = 3'd3;
    localparam logic [2:0] OP_DISABLE = 3'd4;
    localparam logic [7:0] TIMEOUT = 8'(IDLE_TIMEOUT);

    logic [2:0] state_q, state_d, op_q, op_d;
    logic [7:0] addr_q, addr_d, data_q, data_d, mosi_q, mosi_d;
    logic [7:0] idle_q, idle_d, rsp_data_q, rsp_data_d;
    logic       cs_q, cs_d, rsp_valid_q, rsp_valid_d, err_q, err_d;
    logic       cmd_only, last, acc, legal;
    logic [7:0] cmd;

    always_comb begin
        cmd_only    = (op_q == OP_ENABLE) || (op_q == OP_DISABLE);
        last        = (state_q == S_DATA) || (state_q == S_CMD && cmd_only);
        req_ready   = (state_q == S_OFF) || (state_q == S_HOLD) || last;
        acc         = req_valid && req_ready;
        legal       = req_op <= OP_DISABLE;
        cmd         = req_op == 3'd0 ? 8'h03 : req_op == 3'd1 ? 8'h02 :
                      req_op == 3'd2 ? 8'h81 : req_op == 3'd3 ? 8'h82 : 8'h83;
        state_d     = state_q;
        op_d        = op_q;
        addr_d      = addr_q;
        data_d      = data_q;
        mosi_d      = 8'h00;
        idle_d      = idle_q;
        rsp_valid_d = (state_q == S_DATA) && (op_q == OP_READ);
        rsp_data_d  = rsp_valid_d ? miso : rsp_data_q;
        err_d       = acc && !legal;
        // An illegal op is consumed but otherwise behaves like no request.
        if (acc && legal) begin
            state_d = S_CMD;
            op_d    = req_op;
            addr_d  = req_addr;
            data_d  = req_data;
            mosi_d  = cmd;
            idle_d  = 8'h00;
        end else begin
            case (state_q)
                S_CMD: begin
                    state_d = cmd_only ? S_HOLD : op_q == OP_STREAM ? S_DATA : S_ADDR;
                    mosi_d  = cmd_only ? 8'h00 : op_q == OP_STREAM ? data_q : addr_q;
                    idle_d  = 8'h00;
                end
                S_ADDR: begin
                    state_d = S_DATA;
                    mosi_d  = op_q == OP_READ ? 8'h00 : data_q;
                end
                S_DATA: begin
                    state_d = S_HOLD;
                    idle_d  = 8'h00;
                end
                S_HOLD: begin
                    state_d = (idle_q + 8'd1 == TIMEOUT) ? S_OFF : S_HOLD;
                    idle_d  = (idle_q + 8'd1 == TIMEOUT) ? 8'h00 : idle_q + 8'd1;
                end
                default: ;
            endcase
        end
        cs_d = state_d == S_OFF;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_OFF;
            op_q        <= 3'd0;
            addr_q      <= 8'h00;
            data_q      <= 8'h00;
            mosi_q      <= 8'h00;
            idle_q      <= 8'h00;
            cs_q        <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 8'h00;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            mosi_q      <= mosi_d;
            idle_q      <= idle_d;
            cs_q        <= cs_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            err_q       <= err_d;
        end
    end

    assign cs        = cs_q;
    assign mosi      = mosi_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign err       = err_q;
endmodule

// File: tb/tb_byte_cmd_initiator.sv
// tb_byte_cmd_initiator: directed vector table, reset corner case, and random traffic against a byte-queue model.
module tb_byte_cmd_initiator;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [2:0] req_op = 3'd0;
    logic [7:0] req_addr = 8'h00, req_data = 8'h00, miso = 8'h00;
    logic       cs, rsp_valid, err;
    logic [7:0] mosi, rsp_data;
    int         checks = 0, errors = 0;

    byte_cmd_initiator #(.IDLE_TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_addr(req_addr), .req_data(req_data), .cs(cs),
        .mosi(mosi), .miso(miso), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       v;
        logic [2:0] op;
        logic [7:0] addr, data, miso;
        logic       cs;
        logic [7:0] mosi;
        logic       rdy, rv;
        logic [7:0] rd;
        logic       err;
    } vec_t;

    vec_t tbl[31];

    // Model: bytes still to be shown on mosi (front = current byte), plus session state.
    logic [7:0] q[$];
    logic       m_off, m_read, m_rv, m_err;
    logic [7:0] m_rd;
    int         m_idle;

    function automatic logic [19:0] outs();
        return {cs, mosi, req_ready, rsp_valid, rsp_data, err};
    endfunction

    task automatic chk(input string nm, input logic [19:0] act, input logic [19:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got {cs,mosi,rdy,rv,rd,err}=%h expected %h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_off = 1'b1; m_read = 1'b0; m_rv = 1'b0; m_err = 1'b0; m_rd = 8'h00; m_idle = 0;
    endtask

    function automatic logic m_ready();
        return m_off || q.size() <= 1;
    endfunction

    function automatic logic [19:0] m_outs();
        return {m_off, q.size() > 0 ? q[0] : 8'h00, m_ready(), m_rv, m_rd, m_err};
    endfunction

    task automatic model_step();
        logic acc;
        acc = req_valid && m_ready();
        m_rv = q.size() == 1 && m_read;
        if (m_rv) m_rd = miso;
        m_err = acc && req_op > 3'd4;
        if (acc && req_op <= 3'd4) begin
            q.delete();
            case (req_op)
                3'd0: begin q.push_back(8'h03); q.push_back(req_addr); q.push_back(8'h00); end
                3'd1: begin q.push_back(8'h02); q.push_back(req_addr); q.push_back(req_data); end
                3'd2: q.push_back(8'h81);
                3'd3: begin q.push_back(8'h82); q.push_back(req_data); end
                default: q.push_back(8'h83);
            endcase
            m_read = req_op == 3'd0;
            m_off = 1'b0;
            m_idle = 0;
        end else if (q.size() > 0) begin
            void'(q.pop_front());
            m_idle = 0;
        end else if (!m_off) begin
            m_idle++;
            if (m_idle == 4) begin m_off = 1'b1; m_idle = 0; end
        end
    endtask

    initial begin
        tbl = '{
            '{1,3'd1,8'h08,8'h61,8'h00, 1,8'h00,1,0,8'h00,0},
            '{1,3'd3,8'hFF,8'h62,8'h00, 0,8'h02,0,0,8'h00,0},
            '{1,3'd3,8'hFF,8'h62,8'h00, 0,8'h08,0,0,8'h00,0},
            '{1,3'd3,8'hFF,8'h62,8'h00, 0,8'h61,1,0,8'h00,0},
            '{0,3'd0,8'h00,8'h00,8'h00, 0,8'h82,0,0,8'h00,0},
            '{0,3'd0,8'h00,8'h00,8'h00, 0,8'h62,1,0,8'h00,0},
            '{0,3'd0,8'h00,8'h00,8'h00, 0,8'h00,1,0,8'h00,0},
            '{1,3'd6,8'h00,8'h00,8'h00, 0,8'h00,1,0,8'h00,0},
            '{0,3'd0,8'h00,8'h00,8'h00, 0,8'h00,1,0,8'h00,1},
            '{0,3'd0,8'h00,8'h00,8'h00, 0,8'h00,1,0,8'h00,0},
            '{1,3'd0,8'h10,8'h00,8'h00, 1,8'h00,1,0,8'h00,0},
            '{0,3'd0,8'h00,8'h00,8'h00, 0,8'h03,0,0,8'h00,0},
            '{0,3'd0,8'h00,8'h00,8'h5A, 0,8'h10,0,0,8'h00,0},
            '{0,3'd0,8'h00,8'h00,8'hA5, 0,8'h00,1,0,8'h00,0},
            '{0,3'd0,8'h00,8'h00,8'h3C, 0,8'h00,1,1,8'hA5,0},
            '{1,3'd2,8'h00,8'h00,8'h00, 0,8'h00,1,0,8'hA5,0},
            '{0,3'd0,8'h00,8'h00,8'h00, 0,8'h81,1,0,8'hA5,0},
            '{0,3'd0,8'h00,8'h00,8'h00, 0,8'h00,1,0,8'hA5,0},
            '{0,3'd0,8'h00,8'h00,8'h00, 0,8'h00,1,0,8'hA5,0},
            '{0,3'd0,8'h00,8'h00,8'h00, 0,8'h00,1,0,8'hA5,0},
            '{1,3'd4,8'h00,8'h00,8'h00, 0,8'h00,1,0,8'hA5,0},
            '{0,3'd0,8'h00,8'h00,8'h00, 0,8'h83,1,0,8'hA5,0},
            '{0,3'd0,8'h00,8'h00,8'h00, 0,8'h00,1,0,8'hA5,0},
            '{0,3'd0,8'h00,8'h00,8'h00, 0,8'h00,1,0,8'hA5,0},
            '{0,3'd0,8'h00,8'h00,8'h00, 0,8'h00,1,0,8'hA5,0},
            '{0,3'd0,8'h00,8'h00,8'h00, 0,8'h00,1,0,8'hA5,0},
            '{1,3'd1,8'h00,8'h03,8'h00, 1,8'h00,1,0,8'hA5,0},
            '{0,3'd0,8'h00,8'h00,8'h00, 0,8'h02,0,0,8'hA5,0},
            '{0,3'd0,8'h00,8'h00,8'h00, 0,8'h00,0,0,8'hA5,0},
            '{0,3'd0,8'h00,8'h00,8'h00, 0,8'h03,1,0,8'hA5,0},
            '{0,3'd0,8'h00,8'h00,8'h00, 0,8'h00,1,0,8'hA5,0}
        };
        #12 chk("reset_state", outs(), {1'b1, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0});
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 31; i++) begin
            @(negedge clk);
            chk($sformatf("vec%0d", i), outs(), {tbl[i].cs, tbl[i].mosi, tbl[i].rdy, tbl[i].rv, tbl[i].rd, tbl[i].err});
            req_valid = tbl[i].v; req_op = tbl[i].op; req_addr = tbl[i].addr;
            req_data = tbl[i].data; miso = tbl[i].miso;
        end
        // Async reset during the address byte of a WRITE: transaction is dropped.
        @(negedge clk);
        req_valid = 1'b1; req_op = 3'd1; req_addr = 8'hAA; req_data = 8'hBB;
        @(negedge clk) req_valid = 1'b0;
        @(posedge clk) #2 rst_n = 1'b0;
        #1 chk("async_reset", outs(), {1'b1, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0});
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("post_reset%0d", i), outs(), {1'b1, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0});
        end
        model_reset();
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            chk($sformatf("rand%0d", i), outs(), m_outs());
            req_valid = $urandom_range(0, 2) == 0;
            req_op = 3'($urandom_range(0, 7));
            req_addr = 8'($urandom);
            req_data = 8'($urandom);
            miso = 8'($urandom);
            @(posedge clk);
            model_step();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
